unidade_de_busca: RTL and testbench

UNIDADE_DE_BUSCA -- requirements
Module: unidade_de_busca

---
 rtl/busca_pkg.sv | 15 +
 rtl/somador_de_endereco.sv | 21 ++
 rtl/unidade_de_busca.sv | 135 +++++++++++++
 tb/tb_unidade_de_busca.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/busca_pkg.sv
// Shared types and widths for the instruction fetch unit.
package busca_pkg;

  localparam int LARGURA_END            = 8;
  localparam int LARGURA_INSTR          = 8;
  localparam int LARGURA_CONT           = 16;
  localparam int ULTIMO_ENDERECO_PADRAO = 51;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    FIM    = 2'd2
  } estado_t;

endpackage

// File: rtl/somador_de_endereco.sv
// Next-PC adder; with BUSCA_DESVIO_RELATIVO_EN also forms the PC-relative redirect target.
module somador_de_endereco
  import busca_pkg::*;
(
  input  logic [LARGURA_END-1:0] endereco,
`ifdef BUSCA_DESVIO_RELATIVO_EN
  input  logic [LARGURA_END-1:0] pc_base,
  input  logic [LARGURA_END-1:0] deslocamento,
  output logic [LARGURA_END-1:0] alvo_relativo,
`endif
  output logic [LARGURA_END-1:0] proximo
);

  // Both sums wrap modulo 2^LARGURA_END; a negative offset is just its two's complement.
  assign proximo = endereco + LARGURA_END'(1);

`ifdef BUSCA_DESVIO_RELATIVO_EN
  assign alvo_relativo = pc_base + deslocamento;
`endif

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch unit: one-entry output register with stall, redirect and end-of-program halt.
// Optional macro BUSCA_DESVIO_RELATIVO_EN adds modo_relativo for PC-relative redirects.
module unidade_de_busca
  import busca_pkg::*;
#(
  parameter int ULTIMO_ENDERECO = ULTIMO_ENDERECO_PADRAO,
  parameter int PC_INICIAL      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     habilita,
  output logic [LARGURA_END-1:0]   endereco,
  input  logic [LARGURA_INSTR-1:0] instrucao_mem,
  input  logic                     desvio,
  input  logic [LARGURA_END-1:0]   alvo_desvio,
`ifdef BUSCA_DESVIO_RELATIVO_EN
  input  logic                     modo_relativo,
`endif
  input  logic                     pronto_dec,
  output logic [LARGURA_INSTR-1:0] instrucao,
  output logic [LARGURA_END-1:0]   pc_instrucao,
  output logic                     valida,
  output logic                     parado,
  output logic [LARGURA_CONT-1:0]  total_buscas
);

  localparam logic [LARGURA_END-1:0] ULT = LARGURA_END'(ULTIMO_ENDERECO);
  localparam logic [LARGURA_END-1:0] PC0 = LARGURA_END'(PC_INICIAL);

  estado_t                  estado_q, estado_d;
  logic [LARGURA_END-1:0]   endereco_q, endereco_d;
  logic [LARGURA_INSTR-1:0] instrucao_q, instrucao_d;
  logic [LARGURA_END-1:0]   pc_instrucao_q, pc_instrucao_d;
  logic                     valida_q, valida_d;
  logic [LARGURA_CONT-1:0]  total_q, total_d;

  logic [LARGURA_END-1:0]   proximo;
  logic [LARGURA_END-1:0]   alvo;
  logic                     transfere;
  logic                     captura;

`ifdef BUSCA_DESVIO_RELATIVO_EN
  logic [LARGURA_END-1:0]   alvo_relativo;

  somador_de_endereco u_somador (
    .endereco      (endereco_q),
    .pc_base       (pc_instrucao_q),
    .deslocamento  (alvo_desvio),
    .alvo_relativo (alvo_relativo),
    .proximo       (proximo)
  );

  assign alvo = modo_relativo ? alvo_relativo : alvo_desvio;
`else
  somador_de_endereco u_somador (
    .endereco (endereco_q),
    .proximo  (proximo)
  );

  assign alvo = alvo_desvio;
`endif

  assign transfere = valida_q & pronto_dec;
  // Redirect wins over capture; the address guard keeps a bad reset PC from fetching.
  assign captura   = (estado_q == BUSCA) & (~valida_q | transfere) & ~desvio
                   & (endereco_q <= ULT);

  always_comb begin
    estado_d       = estado_q;
    endereco_d     = endereco_q;
    instrucao_d    = instrucao_q;
    pc_instrucao_d = pc_instrucao_q;
    valida_d       = valida_q;
    total_d        = total_q;

    if (transfere && (total_q != {LARGURA_CONT{1'b1}}))
      total_d = total_q + LARGURA_CONT'(1);

    if (desvio) begin
      endereco_d = alvo;
      valida_d   = 1'b0;
      if (alvo > ULT)     estado_d = FIM;
      else if (habilita)  estado_d = BUSCA;
      else                estado_d = OCIOSO;
    end else begin
      if (captura) begin
        instrucao_d    = instrucao_mem;
        pc_instrucao_d = endereco_q;
        valida_d       = 1'b1;
      end else if (transfere) begin
        valida_d = 1'b0;
      end

      unique case (estado_q)
        OCIOSO: if (habilita) estado_d = BUSCA;
        BUSCA: begin
          if (captura) begin
            if (endereco_q == ULT) estado_d = FIM;
            else                   endereco_d = proximo;
          end
          if (!habilita && !(captura && endereco_q == ULT)) estado_d = OCIOSO;
          if (endereco_q > ULT) estado_d = FIM;
        end
        FIM:     estado_d = FIM;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q       <= OCIOSO;
      endereco_q     <= PC0;
      instrucao_q    <= '0;
      pc_instrucao_q <= '0;
      valida_q       <= 1'b0;
      total_q        <= '0;
    end else begin
      estado_q       <= estado_d;
      endereco_q     <= endereco_d;
      instrucao_q    <= instrucao_d;
      pc_instrucao_q <= pc_instrucao_d;
      valida_q       <= valida_d;
      total_q        <= total_d;
    end
  end

  assign endereco     = endereco_q;
  assign instrucao    = instrucao_q;
  assign pc_instrucao = pc_instrucao_q;
  assign valida       = valida_q;
  assign parado       = (estado_q == FIM);
  assign total_buscas = total_q;

endmodule

// File: tb/tb_unidade_de_busca.sv
// Directed bench for unidade_de_busca; memory returns address + 8'h10.
module tb_unidade_de_busca;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        habilita = 1'b0;
  logic [7:0]  endereco;
  logic [7:0]  instrucao_mem;
  logic        desvio = 1'b0;
  logic [7:0]  alvo_desvio = 8'd0;
  logic        pronto_dec = 1'b0;
  logic [7:0]  instrucao;
  logic [7:0]  pc_instrucao;
  logic        valida;
  logic        parado;
  logic [15:0] total_buscas;
`ifdef BUSCA_DESVIO_RELATIVO_EN
  logic        modo_relativo = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign instrucao_mem = endereco + 8'h10;

  unidade_de_busca dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .endereco      (endereco),
    .instrucao_mem (instrucao_mem),
    .desvio        (desvio),
    .alvo_desvio   (alvo_desvio),
`ifdef BUSCA_DESVIO_RELATIVO_EN
    .modo_relativo (modo_relativo),
`endif
    .pronto_dec    (pronto_dec),
    .instrucao     (instrucao),
    .pc_instrucao  (pc_instrucao),
    .valida        (valida),
    .parado        (parado),
    .total_buscas  (total_buscas)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (endereco !== 8'd0)      begin errors++; $display("FAIL rst_endereco got=%0d exp=0", endereco); end
    checks++; if (instrucao !== 8'd0)     begin errors++; $display("FAIL rst_instrucao got=%0h exp=0", instrucao); end
    checks++; if (pc_instrucao !== 8'd0)  begin errors++; $display("FAIL rst_pc got=%0d exp=0", pc_instrucao); end
    checks++; if (valida !== 1'b0)        begin errors++; $display("FAIL rst_valida got=%b exp=0", valida); end
    checks++; if (parado !== 1'b0)        begin errors++; $display("FAIL rst_parado got=%b exp=0", parado); end
    checks++; if (total_buscas !== 16'd0) begin errors++; $display("FAIL rst_total got=%0d exp=0", total_buscas); end
    reset = 1'b1;
  endtask

  task automatic test_sequencia();
    habilita = 1'b1; pronto_dec = 1'b1;
    step();
    checks++; if (valida !== 1'b0) begin errors++; $display("FAIL seq_valida_edge1 got=%b exp=0", valida); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (valida !== 1'b1) begin errors++; $display("FAIL seq_valida[%0d] got=%b exp=1", k, valida); end
      checks++; if (instrucao !== 8'h10 + 8'(k)) begin errors++; $display("FAIL seq_instr[%0d] got=%0h exp=%0h", k, instrucao, 8'h10 + 8'(k)); end
      checks++; if (pc_instrucao !== 8'(k)) begin errors++; $display("FAIL seq_pc[%0d] got=%0d exp=%0d", k, pc_instrucao, k); end
      checks++; if (total_buscas !== 16'(k)) begin errors++; $display("FAIL seq_total[%0d] got=%0d exp=%0d", k, total_buscas, k); end
    end
  endtask

  task automatic test_stall();
    step();
    checks++; if (instrucao !== 8'h13) begin errors++; $display("FAIL stall_pre_instr got=%0h exp=13", instrucao); end
    pronto_dec = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (instrucao !== 8'h13)    begin errors++; $display("FAIL stall_instr[%0d] got=%0h exp=13", k, instrucao); end
      checks++; if (pc_instrucao !== 8'd3)  begin errors++; $display("FAIL stall_pc[%0d] got=%0d exp=3", k, pc_instrucao); end
      checks++; if (endereco !== 8'd4)      begin errors++; $display("FAIL stall_end[%0d] got=%0d exp=4", k, endereco); end
      checks++; if (total_buscas !== 16'd3) begin errors++; $display("FAIL stall_total[%0d] got=%0d exp=3", k, total_buscas); end
      checks++; if (valida !== 1'b1)        begin errors++; $display("FAIL stall_valida[%0d] got=%b exp=1", k, valida); end
    end
    pronto_dec = 1'b1;
    step();
    checks++; if (instrucao !== 8'h14)    begin errors++; $display("FAIL release_instr got=%0h exp=14", instrucao); end
    checks++; if (pc_instrucao !== 8'd4)  begin errors++; $display("FAIL release_pc got=%0d exp=4", pc_instrucao); end
    checks++; if (total_buscas !== 16'd4) begin errors++; $display("FAIL release_total got=%0d exp=4", total_buscas); end
    step();
    checks++; if (instrucao !== 8'h15)    begin errors++; $display("FAIL release2_instr got=%0h exp=15", instrucao); end
    checks++; if (total_buscas !== 16'd5) begin errors++; $display("FAIL release2_total got=%0d exp=5", total_buscas); end
  endtask

  task automatic test_fim();
    int n = 0;
    while (pc_instrucao !== 8'd51 && n < 80) begin
      step();
      n++;
    end
    checks++; if (pc_instrucao !== 8'd51) begin errors++; $display("FAIL fim_timeout pc got=%0d exp=51", pc_instrucao); end
    checks++; if (parado !== 1'b1)        begin errors++; $display("FAIL fim_parado got=%b exp=1", parado); end
    checks++; if (instrucao !== 8'h43)    begin errors++; $display("FAIL fim_instr got=%0h exp=43", instrucao); end
    checks++; if (endereco !== 8'd51)     begin errors++; $display("FAIL fim_end got=%0d exp=51", endereco); end
    checks++; if (total_buscas !== 16'd51) begin errors++; $display("FAIL fim_total_pre got=%0d exp=51", total_buscas); end
    step();
    checks++; if (valida !== 1'b0)         begin errors++; $display("FAIL fim_valida got=%b exp=0", valida); end
    checks++; if (total_buscas !== 16'd52) begin errors++; $display("FAIL fim_total got=%0d exp=52", total_buscas); end
    step();
    checks++; if (valida !== 1'b0 || parado !== 1'b1 || endereco !== 8'd51)
      begin errors++; $display("FAIL fim_hold valida=%b parado=%b end=%0d exp 0/1/51", valida, parado, endereco); end
  endtask

  task automatic test_desvio();
    pronto_dec = 1'b0; desvio = 1'b1; alvo_desvio = 8'd0;
    step();
    desvio = 1'b0;
    checks++; if (parado !== 1'b0 || endereco !== 8'd0) begin errors++; $display("FAIL desvio_restart parado=%b end=%0d exp 0/0", parado, endereco); end
    step();
    checks++; if (valida !== 1'b1 || pc_instrucao !== 8'd0) begin errors++; $display("FAIL desvio_cap valida=%b pc=%0d exp 1/0", valida, pc_instrucao); end
    desvio = 1'b1; alvo_desvio = 8'd20;
    step();
    desvio = 1'b0;
    checks++; if (valida !== 1'b0)         begin errors++; $display("FAIL desvio_flush got=%b exp=0", valida); end
    checks++; if (endereco !== 8'd20)      begin errors++; $display("FAIL desvio_end got=%0d exp=20", endereco); end
    checks++; if (total_buscas !== 16'd52) begin errors++; $display("FAIL desvio_total got=%0d exp=52", total_buscas); end
    step();
    checks++; if (pc_instrucao !== 8'd20 || instrucao !== 8'h24 || valida !== 1'b1)
      begin errors++; $display("FAIL desvio_target pc=%0d instr=%0h valida=%b exp 20/24/1", pc_instrucao, instrucao, valida); end
    pronto_dec = 1'b1; desvio = 1'b1; alvo_desvio = 8'd60;
    step();
    desvio = 1'b0; pronto_dec = 1'b0;
    checks++; if (parado !== 1'b1)         begin errors++; $display("FAIL desvio_far_parado got=%b exp=1", parado); end
    checks++; if (total_buscas !== 16'd53) begin errors++; $display("FAIL desvio_far_total got=%0d exp=53", total_buscas); end
    checks++; if (endereco !== 8'd60)      begin errors++; $display("FAIL desvio_far_end got=%0d exp=60", endereco); end
    step();
    checks++; if (valida !== 1'b0 || endereco !== 8'd60 || parado !== 1'b1)
      begin errors++; $display("FAIL desvio_far_hold valida=%b end=%0d parado=%b exp 0/60/1", valida, endereco, parado); end
  endtask

  task automatic test_relativo();
    desvio = 1'b1; alvo_desvio = 8'd10;
    step();
    desvio = 1'b0;
    step();
    checks++; if (pc_instrucao !== 8'd10 || valida !== 1'b1) begin errors++; $display("FAIL rel_setup pc=%0d valida=%b exp 10/1", pc_instrucao, valida); end
    desvio = 1'b1; alvo_desvio = 8'hFC;
`ifdef BUSCA_DESVIO_RELATIVO_EN
    modo_relativo = 1'b1;
`endif
    step();
    desvio = 1'b0;
`ifdef BUSCA_DESVIO_RELATIVO_EN
    modo_relativo = 1'b0;
    checks++; if (endereco !== 8'd6 || parado !== 1'b0) begin errors++; $display("FAIL rel_target end=%0d parado=%b exp 6/0", endereco, parado); end
`else
    checks++; if (endereco !== 8'd252 || parado !== 1'b1) begin errors++; $display("FAIL abs_target end=%0d parado=%b exp 252/1", endereco, parado); end
`endif
  endtask

  task automatic test_reset_stall();
    pronto_dec = 1'b0; desvio = 1'b1; alvo_desvio = 8'd30;
    step();
    desvio = 1'b0;
    step();
    checks++; if (pc_instrucao !== 8'd30 || valida !== 1'b1) begin errors++; $display("FAIL rst_stall_setup pc=%0d valida=%b exp 30/1", pc_instrucao, valida); end
    desvio = 1'b1; alvo_desvio = 8'd40;
    #3 reset = 1'b0;
    #1;
    checks++; if (valida !== 1'b0 || instrucao !== 8'd0 || pc_instrucao !== 8'd0 || endereco !== 8'd0 || total_buscas !== 16'd0 || parado !== 1'b0)
      begin errors++; $display("FAIL rst_async valida=%b instr=%0h pc=%0d end=%0d total=%0d parado=%b exp all 0", valida, instrucao, pc_instrucao, endereco, total_buscas, parado); end
    desvio = 1'b0; pronto_dec = 1'b1; habilita = 1'b1;
    step();
    #2 reset = 1'b1;
    step();
    step();
    checks++; if (valida !== 1'b1 || instrucao !== 8'h10 || pc_instrucao !== 8'd0)
      begin errors++; $display("FAIL rst_first valida=%b instr=%0h pc=%0d exp 1/10/0", valida, instrucao, pc_instrucao); end
  endtask

  initial begin
    test_reset();
    test_sequencia();
    test_stall();
    test_fim();
    test_desvio();
    test_relativo();
    test_reset_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
